pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed-field inter-stage control registers (ID/EX, EX/MEM, MEM/WB). It carries a generic control bundle and data bundle under a valid/ready handshake, with optional 2-entry skid buffering, synchronous flush (bubble insertion) and an occupancy report. Each stage boundary in the ARM pipeline instantiates one of these.

---
 rtl/pipe_stage_reg.sv | 193 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register placed at each stage boundary (ID/EX,
// EX/MEM, MEM/WB, ...). It carries a control bundle and a data bundle under a
// valid/ready handshake.
//
// SKID=1 : 2-entry skid buffer. in_ready is decoded from registered state only,
//          so there is no combinational path from out_ready to in_ready.
// SKID=0 : single register. in_ready = !out_valid || out_ready (combinational).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (clears valids and outputs)
//   flush      synchronous bubble insertion; drops every held payload and any
//              payload presented in the same cycle
//   in_valid   upstream presents a payload
//   in_ready   stage can accept this cycle
//   ctrl_in    control bundle (write enables, selects, ALU control, status)
//   data_in    data bundle (operands, results, destination index)
//   out_valid  ctrl_out/data_out hold a live payload
//   out_ready  downstream accepts this cycle
//   ctrl_out   control bundle, forced to zero while out_valid=0 (bubble)
//   data_out   data bundle, holds its last value while out_valid=0
//   occupancy  number of payloads held (0..2; at most 1 when SKID=0)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 32,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Output-side (main) register: this is what downstream sees.
  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [DATA_W-1:0] data_p1;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_p1 && out_ready;

  assign out_valid = vld_p1;
  // An empty stage must look like a bubble: no write enables downstream.
  assign ctrl_out  = vld_p1 ? ctrl_p1 : '0;
  assign data_out  = data_p1;

  if (SKID) begin : g_skid

    state_t state_p1;
    state_t state_nxt;

    // Skid (overflow) register, only meaningful in ST_TWO.
    logic [CTRL_W-1:0] ctrl_p0;
    logic [DATA_W-1:0] data_p0;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_p1 <= ST_EMPTY;
      end else begin
        state_p1 <= state_nxt;
      end
    end

    always_comb begin
      state_nxt      = state_p1;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
        // Flush wins over both transfers; nothing is loaded.
        state_nxt = ST_EMPTY;
      end else begin
        case (state_p1)
          ST_EMPTY: begin
            if (in_xfer) begin
              load_main_in = 1'b1;
              state_nxt    = ST_ONE;
            end
          end
          ST_ONE: begin
            if (in_xfer && out_xfer) begin
              load_main_in = 1'b1;
            end else if (out_xfer) begin
              state_nxt = ST_EMPTY;
            end else if (in_xfer) begin
              load_skid = 1'b1;
              state_nxt = ST_TWO;
            end
          end
          ST_TWO: begin
            // in_ready is low here, so only the output side can move.
            if (out_xfer) begin
              load_main_skid = 1'b1;
              state_nxt      = ST_ONE;
            end
          end
          default: begin
            state_nxt = ST_EMPTY;
          end
        endcase
      end
    end

    // ---- stage p0: skid register (input side) ----
    always_ff @(posedge clk) begin
      if (load_skid) begin
        ctrl_p0 <= ctrl_in;
        data_p0 <= data_in;
      end
    end

    // ---- stage p1: main register (output side) ----
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ctrl_p1 <= '0;
        data_p1 <= '0;
      end else if (load_main_in) begin
        ctrl_p1 <= ctrl_in;
        data_p1 <= data_in;
      end else if (load_main_skid) begin
        ctrl_p1 <= ctrl_p0;
        data_p1 <= data_p0;
      end
    end

    assign vld_p1   = (state_p1 == ST_ONE) || (state_p1 == ST_TWO);
    assign in_ready = (state_p1 != ST_TWO);

    always_comb begin
      occupancy = 2'd0;
      case (state_p1)
        ST_ONE:  occupancy = 2'd1;
        ST_TWO:  occupancy = 2'd2;
        default: occupancy = 2'd0;
      endcase
    end

  end else begin : g_single

    // ---- stage p1: single register ----
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p1 <= 1'b0;
      end else if (flush) begin
        vld_p1 <= 1'b0;
      end else if (in_xfer) begin
        vld_p1 <= 1'b1;
      end else if (out_xfer) begin
        vld_p1 <= 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ctrl_p1 <= '0;
        data_p1 <= '0;
      end else if (in_xfer && !flush) begin
        ctrl_p1 <= ctrl_in;
        data_p1 <= data_in;
      end
    end

    assign in_ready  = !vld_p1 || out_ready;
    assign occupancy = {1'b0, vld_p1};

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. One instance with SKID=1 (u_s1) and one
// with SKID=0 (u_s0) share clock and reset; each has its own handshake inputs.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;

  logic        s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [6:0]  s1_ctrl_in, s1_ctrl_out;
  logic [31:0] s1_data_in, s1_data_out;
  logic [1:0]  s1_occ;

  logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [6:0]  s0_ctrl_in, s0_ctrl_out;
  logic [31:0] s0_data_in, s0_data_out;
  logic [1:0]  s0_occ;

  int errors;
  int checks;

  pipe_stage_reg #(.CTRL_W(7), .DATA_W(32), .SKID(1'b1)) u_s1 (
    .clk(clk), .reset(reset), .flush(s1_flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .ctrl_in(s1_ctrl_in), .data_in(s1_data_in),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready),
    .ctrl_out(s1_ctrl_out), .data_out(s1_data_out),
    .occupancy(s1_occ)
  );

  pipe_stage_reg #(.CTRL_W(7), .DATA_W(32), .SKID(1'b0)) u_s0 (
    .clk(clk), .reset(reset), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .ctrl_in(s0_ctrl_in), .data_in(s0_data_in),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .ctrl_out(s0_ctrl_out), .data_out(s0_data_out),
    .occupancy(s0_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    s1_out_ready = 1'b0; s0_out_ready = 1'b0;
    s1_in_valid = 1'b1; s1_data_in = 32'hAB; s1_ctrl_in = 7'h7F;
    s0_in_valid = 1'b1; s0_data_in = 32'hCD; s0_ctrl_in = 7'h3C;
    tick();
    s1_data_in = 32'hAC;
    tick();
    checks++;
    if (s1_occ !== 2'd2) begin
      errors++; $display("FAIL pre_reset_s1_occ: got %0d want 2", s1_occ);
    end
    checks++;
    if (s0_out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_s0_valid: got %b want 1", s0_out_valid);
    end
    s1_in_valid = 1'b0; s0_in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if (s1_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_s1_out_valid: got %b want 0", s1_out_valid);
    end
    checks++;
    if (s1_ctrl_out !== 7'h00) begin
      errors++; $display("FAIL reset_s1_ctrl_out: got %h want 00", s1_ctrl_out);
    end
    checks++;
    if (s1_data_out !== 32'h0) begin
      errors++; $display("FAIL reset_s1_data_out: got %h want 0", s1_data_out);
    end
    checks++;
    if (s1_occ !== 2'd0) begin
      errors++; $display("FAIL reset_s1_occ: got %0d want 0", s1_occ);
    end
    checks++;
    if (s1_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s1_in_ready: got %b want 1", s1_in_ready);
    end
    checks++;
    if (s0_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_s0_out_valid: got %b want 0", s0_out_valid);
    end
    checks++;
    if (s0_ctrl_out !== 7'h00) begin
      errors++; $display("FAIL reset_s0_ctrl_out: got %h want 00", s0_ctrl_out);
    end
    checks++;
    if (s0_data_out !== 32'h0) begin
      errors++; $display("FAIL reset_s0_data_out: got %h want 0", s0_data_out);
    end
    checks++;
    if (s0_occ !== 2'd0) begin
      errors++; $display("FAIL reset_s0_occ: got %0d want 0", s0_occ);
    end
    checks++;
    if (s0_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s0_in_ready: got %b want 1", s0_in_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (s1_out_valid !== 1'b0 || s0_out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_valid: got s1=%b s0=%b want 0 0",
                         s1_out_valid, s0_out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_streaming();
    s1_out_ready = 1'b1;
    s1_in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s1_data_in = 32'h10 + 32'(i);
      s1_ctrl_in = 7'h5A;
      #1;
      checks++;
      if (s1_in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, s1_in_ready);
      end
      tick();
      checks++;
      if (s1_out_valid !== 1'b1 || s1_data_out !== 32'h10 + 32'(i) ||
          s1_ctrl_out !== 7'h5A) begin
        errors++;
        $display("FAIL stream_out[%0d]: got v=%b d=%h c=%h want v=1 d=%h c=5a",
                 i, s1_out_valid, s1_data_out, s1_ctrl_out, 32'h10 + 32'(i));
      end
    end
    s1_in_valid = 1'b0;
    tick();
    checks++;
    if (s1_out_valid !== 1'b0 || s1_ctrl_out !== 7'h00 ||
        s1_data_out !== 32'h17 || s1_occ !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b c=%h d=%h occ=%0d want v=0 c=00 d=17 occ=0",
               s1_out_valid, s1_ctrl_out, s1_data_out, s1_occ);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    s1_out_ready = 1'b0;
    s1_in_valid  = 1'b1;
    s1_data_in = 32'h1; s1_ctrl_in = 7'h11;
    tick();
    checks++;
    if (s1_data_out !== 32'h1 || s1_occ !== 2'd1 || s1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_load_a: got d=%h occ=%0d rdy=%b want d=1 occ=1 rdy=1",
               s1_data_out, s1_occ, s1_in_ready);
    end
    s1_data_in = 32'h2; s1_ctrl_in = 7'h22;
    tick();
    checks++;
    if (s1_data_out !== 32'h1 || s1_occ !== 2'd2 || s1_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got d=%h occ=%0d rdy=%b want d=1 occ=2 rdy=0",
               s1_data_out, s1_occ, s1_in_ready);
    end
    s1_data_in = 32'h3; s1_ctrl_in = 7'h33;
    tick();
    checks++;
    if (s1_data_out !== 32'h1 || s1_ctrl_out !== 7'h11 ||
        s1_occ !== 2'd2 || s1_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold_c: got d=%h c=%h occ=%0d rdy=%b want d=1 c=11 occ=2 rdy=0",
               s1_data_out, s1_ctrl_out, s1_occ, s1_in_ready);
    end
    s1_out_ready = 1'b1;
    #1;
    checks++;
    if (s1_out_valid !== 1'b1 || s1_data_out !== 32'h1) begin
      errors++;
      $display("FAIL bp_deliver_a: got v=%b d=%h want v=1 d=1", s1_out_valid, s1_data_out);
    end
    tick();
    checks++;
    if (s1_data_out !== 32'h2 || s1_ctrl_out !== 7'h22 ||
        s1_occ !== 2'd1 || s1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_deliver_b: got d=%h c=%h occ=%0d rdy=%b want d=2 c=22 occ=1 rdy=1",
               s1_data_out, s1_ctrl_out, s1_occ, s1_in_ready);
    end
    tick();
    checks++;
    if (s1_out_valid !== 1'b1 || s1_data_out !== 32'h3 ||
        s1_ctrl_out !== 7'h33 || s1_occ !== 2'd1) begin
      errors++;
      $display("FAIL bp_deliver_c: got v=%b d=%h c=%h occ=%0d want v=1 d=3 c=33 occ=1",
               s1_out_valid, s1_data_out, s1_ctrl_out, s1_occ);
    end
    s1_in_valid = 1'b0;
    tick();
    checks++;
    if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0) begin
      errors++;
      $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", s1_out_valid, s1_occ);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    s1_out_ready = 1'b0;
    s1_in_valid  = 1'b1;
    s1_data_in = 32'h41; s1_ctrl_in = 7'h41;
    tick();
    s1_data_in = 32'h42; s1_ctrl_in = 7'h42;
    tick();
    checks++;
    if (s1_occ !== 2'd2) begin
      errors++; $display("FAIL flush_pre_occ: got %0d want 2", s1_occ);
    end
    s1_flush = 1'b1;
    s1_data_in = 32'h4; s1_ctrl_in = 7'h44;
    tick();
    s1_flush = 1'b0;
    s1_in_valid = 1'b0;
    checks++;
    if (s1_out_valid !== 1'b0 || s1_ctrl_out !== 7'h00 || s1_occ !== 2'd0 ||
        s1_in_ready !== 1'b1 || s1_data_out !== 32'h41) begin
      errors++;
      $display("FAIL flush_result: got v=%b c=%h occ=%0d rdy=%b d=%h want v=0 c=00 occ=0 rdy=1 d=41",
               s1_out_valid, s1_ctrl_out, s1_occ, s1_in_ready, s1_data_out);
    end
    s1_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s1_out_valid !== 1'b0 || s1_data_out !== 32'h41) begin
        errors++;
        $display("FAIL flush_no_d[%0d]: got v=%b d=%h want v=0 d=41",
                 i, s1_out_valid, s1_data_out);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  logic [31:0] s0_din_seq  [4] = '{32'h20, 32'h21, 32'h21, 32'h22};
  logic        s0_ordy_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic        s0_exp_rdy  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] s0_exp_dout [4] = '{32'h20, 32'h20, 32'h21, 32'h22};

  task automatic test_skid0();
    s0_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0_data_in   = s0_din_seq[i];
      s0_ctrl_in   = s0_din_seq[i][6:0];
      s0_out_ready = s0_ordy_seq[i];
      #1;
      checks++;
      if (s0_in_ready !== s0_exp_rdy[i]) begin
        errors++;
        $display("FAIL s0_in_ready[%0d]: got %b want %b", i, s0_in_ready, s0_exp_rdy[i]);
      end
      tick();
      checks++;
      if (s0_out_valid !== 1'b1 || s0_data_out !== s0_exp_dout[i] ||
          s0_ctrl_out !== s0_exp_dout[i][6:0] || s0_occ !== 2'd1) begin
        errors++;
        $display("FAIL s0_out[%0d]: got v=%b d=%h c=%h occ=%0d want v=1 d=%h occ=1",
                 i, s0_out_valid, s0_data_out, s0_ctrl_out, s0_occ, s0_exp_dout[i]);
      end
    end
    s0_in_valid  = 1'b0;
    s0_out_ready = 1'b1;
    tick();
    checks++;
    if (s0_out_valid !== 1'b0 || s0_occ !== 2'd0 || s0_ctrl_out !== 7'h00) begin
      errors++;
      $display("FAIL s0_drain: got v=%b occ=%0d c=%h want v=0 occ=0 c=00",
               s0_out_valid, s0_occ, s0_ctrl_out);
    end
    // Flush with in_ready=1: the presented payload must be dropped.
    s0_flush = 1'b1;
    s0_in_valid = 1'b1; s0_data_in = 32'h99; s0_ctrl_in = 7'h19;
    tick();
    s0_flush = 1'b0;
    s0_in_valid = 1'b0;
    checks++;
    if (s0_out_valid !== 1'b0 || s0_data_out !== 32'h22) begin
      errors++;
      $display("FAIL s0_flush: got v=%b d=%h want v=0 d=22", s0_out_valid, s0_data_out);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    s1_out_ready = 1'b0;
    s1_in_valid  = 1'b1;
    s1_data_in = 32'h30; s1_ctrl_in = 7'h30;
    tick();
    s1_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s1_data_in = 32'h31 + 32'(i);
      s1_ctrl_in = 7'h31 + 7'(i);
      #1;
      checks++;
      if (s1_out_valid !== 1'b1 || s1_data_out !== 32'h30 + 32'(i) ||
          s1_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_deliver[%0d]: got v=%b d=%h rdy=%b want v=1 d=%h rdy=1",
                 i, s1_out_valid, s1_data_out, s1_in_ready, 32'h30 + 32'(i));
      end
      tick();
      checks++;
      if (s1_occ !== 2'd1 || s1_data_out !== 32'h31 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_occ[%0d]: got occ=%0d d=%h want occ=1 d=%h",
                 i, s1_occ, s1_data_out, 32'h31 + 32'(i));
      end
    end
    s1_in_valid = 1'b0;
    tick();
    checks++;
    if (s1_occ !== 2'd0 || s1_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got occ=%0d v=%b want occ=0 v=0", s1_occ, s1_out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    s1_flush = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b0;
    s1_ctrl_in = '0; s1_data_in = '0;
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
    s0_ctrl_in = '0; s0_data_in = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
